operand_stage: RTL and testbench
================================

Name: operand_stage

Overview:
- ID/EX boundary stage sitting directly downstream of the register file.
- Consumes the registered rs1/rs2 values and their register indices, resolves RAW hazards by forwarding from EX/MEM/late-WB, and detects load-use hazards (one-bubble stall).
- Drives the EX-stage operand pipeline register with a valid/ready handshake.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register index width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
valid_i  input  1  decoded instruction valid, aligned with regfile read data
rs1_i  input  XLEN  regfile rs1 data
rs2_i  input  XLEN  regfile rs2 data
sel_rs1_i  input  REG_AW  index of rs1_i
sel_rs2_i  input  REG_AW  index of rs2_i
sel_rd_i  input  REG_AW  destination of incoming instruction
rd_we_i  input  1  incoming instruction writes rd
is_load_i  input  1  incoming instruction is a load
ex_result_i  input  XLEN  combinational ALU result of instruction held in op_* registers
mem_valid_i  input  1  MEM stage holds a valid instruction
mem_we_i  input  1  MEM instruction writes rd
mem_sel_rd_i  input  REG_AW  MEM destination
mem_result_i  input  XLEN  MEM result (ALU result or load data)
wb_we_i  input  1  regfile write enable (same signal the regfile gets)
wb_sel_rd_i  input  REG_AW  regfile write index
wb_rd_i  input  XLEN  regfile write data
flush_i  input  1  kill incoming and held instruction
ex_ready_i  input  1  EX accepts op_* this cycle
stall_o  output  1  upstream must hold sel_rs*/instruction fields
op_valid_o  output  1  operands valid to EX
op_rs1_o  output  XLEN  resolved rs1
op_rs2_o  output  XLEN  resolved rs2
op_sel_rd_o  output  REG_AW  destination
op_rd_we_o  output  1  writes rd
op_is_load_o  output  1  is load

Behaviour:
- Reset (async, rst_n low): all op_* outputs 0, late-WB register cleared (we=0, idx=0, data=0). stall_o is combinational and reads 0 while in reset.
- Late-WB register: unconditionally captures {wb_we_i, wb_sel_rd_i, wb_rd_i} every cycle. This covers the write that lands on the same edge at which the regfile sampled stale data.
- Operand resolution, per source s, in priority order:
  1. EX: op_valid_o && op_rd_we_o && op_sel_rd_o==sel_s -> ex_result_i.
  2. MEM: mem_valid_i && mem_we_i && mem_sel_rd_i==sel_s -> mem_result_i.
  3. Late WB: lwb_we && lwb_idx==sel_s -> lwb_data.
  4. Otherwise the regfile value.
  - sel_s==0 is never forwarded and always resolves to 0.
- Load-use hazard: valid_i && op_valid_o && op_is_load_o && op_rd_we_o && op_sel_rd_o!=0 && (op_sel_rd_o==sel_rs1_i || op_sel_rd_o==sel_rs2_i). A load in EX cannot forward.
- stall_o = (load_use || (op_valid_o && !ex_ready_i)) && !flush_i.
- Register update each edge:
  - flush_i: op_valid_o<=0; all other op_* fields hold their values.
  - else if op_valid_o && !ex_ready_i: hold all op_*.
  - else if load_use: op_valid_o<=0 (bubble); the load advances, and the held instruction re-resolves next cycle via MEM.
  - else: op_valid_o<=valid_i; when valid_i, load resolved operands and the rd/we/load fields.
- Latency: 1 cycle from valid_i to op_valid_o when no hazard; 2 cycles on load-use.
- Flush overrides stall and load-use in the same cycle; the incoming instruction is dropped.
- Bubble/invalid instructions never trigger forwarding or hazards.

Optional Feature:
- Macro RISKY_OPSTAGE_PERF_EN.
- Defined: adds outputs perf_stall_cnt_o (32) and perf_fwd_cnt_o (32). These are async-reset-to-0 counters that wrap at 2^32.
  - Stall counter: +1 each cycle stall_o=1.
  - Forward counter: +1 each cycle an instruction is accepted with at least one source forwarded.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package riscy_pkg: XLEN, REG_AW, and typedef fwd_sel_e {FWD_RF, FWD_EX, FWD_MEM, FWD_WB}.
- One sub-module, operand_fwd_mux: purely combinational priority select for one source. It is instantiated twice.

Test Plan:
- Reset mid-operation with op_valid_o=1 -> all op_* 0, stall_o 0, late-WB cleared; the next instruction reads the regfile value.
- Back-to-back ADD x5 then ADD x6,x5,x0 with ex_result_i=0x11 -> op_rs1_o=0x11.
- LW x7 in EX then ADD x8,x7,x7 -> stall_o=1 for 1 cycle and a bubble; next cycle with mem_result_i=0xDEAD, op_rs1_o=op_rs2_o=0xDEAD.
- Write x3=0x55 on the edge the regfile samples stale x3=0 -> op_rs1_o=0x55 via late-WB. Simultaneous MEM x3=0x66 -> 0x66 wins.
- Source x0 while MEM writes x0=0xFF -> operand 0.
- ex_ready_i low 3 cycles -> op_* held and stall_o=1. flush_i asserted during the hold -> op_valid_o=0 next cycle and stall_o drops.

Source files
------------

// File: rtl/riscy_pkg.sv
// Shared types and widths for the riscy ID/EX operand path.
// Forwarding source encoding used by operand_fwd_mux and operand_stage.
package riscy_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_EX,
    FWD_MEM,
    FWD_WB
  } fwd_sel_e;

endpackage

// File: rtl/operand_fwd_mux.sv
// Priority forwarding select for one source operand.
// EX beats MEM beats late-WB beats regfile; index 0 never forwards.
module operand_fwd_mux
  import riscy_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_sel,
  input  logic              i_ex_en,
  input  logic [REG_AW-1:0] i_ex_idx,
  input  logic              i_mem_en,
  input  logic [REG_AW-1:0] i_mem_idx,
  input  logic              i_wb_en,
  input  logic [REG_AW-1:0] i_wb_idx,
  output fwd_sel_e          o_src
);

  logic w_zero;

  assign w_zero = (i_sel == '0);

  // Pick the youngest in-flight producer of this index.
  always_comb begin
    o_src = FWD_RF;
    if (w_zero)
      o_src = FWD_RF;
    else if (i_ex_en && i_ex_idx == i_sel)
      o_src = FWD_EX;
    else if (i_mem_en && i_mem_idx == i_sel)
      o_src = FWD_MEM;
    else if (i_wb_en && i_wb_idx == i_sel)
      o_src = FWD_WB;
  end

endmodule

// File: rtl/operand_stage.sv
// ID/EX operand stage: forwarding, load-use stall, op_* register.
// Optional perf counters enabled by RISKY_OPSTAGE_PERF_EN.
module operand_stage
  import riscy_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic [XLEN-1:0]   rs2_i,
  input  logic [REG_AW-1:0] sel_rs1_i,
  input  logic [REG_AW-1:0] sel_rs2_i,
  input  logic [REG_AW-1:0] sel_rd_i,
  input  logic              rd_we_i,
  input  logic              is_load_i,
  input  logic [XLEN-1:0]   ex_result_i,
  input  logic              mem_valid_i,
  input  logic              mem_we_i,
  input  logic [REG_AW-1:0] mem_sel_rd_i,
  input  logic [XLEN-1:0]   mem_result_i,
  input  logic              wb_we_i,
  input  logic [REG_AW-1:0] wb_sel_rd_i,
  input  logic [XLEN-1:0]   wb_rd_i,
  input  logic              flush_i,
  input  logic              ex_ready_i,
  output logic              stall_o,
  output logic              op_valid_o,
  output logic [XLEN-1:0]   op_rs1_o,
  output logic [XLEN-1:0]   op_rs2_o,
  output logic [REG_AW-1:0] op_sel_rd_o,
  output logic              op_rd_we_o,
  output logic              op_is_load_o
`ifdef RISKY_OPSTAGE_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt_o,
  output logic [31:0]       perf_fwd_cnt_o
`endif
);

  logic              r_op_valid;
  logic [XLEN-1:0]   r_op_rs1;
  logic [XLEN-1:0]   r_op_rs2;
  logic [REG_AW-1:0] r_op_sel_rd;
  logic              r_op_rd_we;
  logic              r_op_is_load;

  logic              r_lwb_we;
  logic [REG_AW-1:0] r_lwb_idx;
  logic [XLEN-1:0]   r_lwb_data;

  logic              w_ex_en;
  logic              w_mem_en;
  logic              w_hold;
  logic              w_load_use;
  logic              w_stall;
  fwd_sel_e          w_src1;
  fwd_sel_e          w_src2;
  logic [XLEN-1:0]   w_rs1;
  logic [XLEN-1:0]   w_rs2;

  assign w_ex_en  = r_op_valid && r_op_rd_we;
  assign w_mem_en = mem_valid_i && mem_we_i;
  assign w_hold   = r_op_valid && !ex_ready_i;

  // A load sitting in EX has no data yet, so its consumer waits one cycle.
  assign w_load_use = valid_i && r_op_valid
                   && r_op_is_load && r_op_rd_we
                   && (r_op_sel_rd != '0)
                   && ((r_op_sel_rd == sel_rs1_i)
                    || (r_op_sel_rd == sel_rs2_i));

  assign w_stall = (w_load_use || w_hold) && !flush_i;
  assign stall_o = w_stall;

  operand_fwd_mux #(
    .REG_AW(REG_AW)
  ) u_fwd_rs1 (
    .i_sel    (sel_rs1_i),
    .i_ex_en  (w_ex_en),
    .i_ex_idx (r_op_sel_rd),
    .i_mem_en (w_mem_en),
    .i_mem_idx(mem_sel_rd_i),
    .i_wb_en  (r_lwb_we),
    .i_wb_idx (r_lwb_idx),
    .o_src    (w_src1)
  );

  operand_fwd_mux #(
    .REG_AW(REG_AW)
  ) u_fwd_rs2 (
    .i_sel    (sel_rs2_i),
    .i_ex_en  (w_ex_en),
    .i_ex_idx (r_op_sel_rd),
    .i_mem_en (w_mem_en),
    .i_mem_idx(mem_sel_rd_i),
    .i_wb_en  (r_lwb_we),
    .i_wb_idx (r_lwb_idx),
    .o_src    (w_src2)
  );

  // Steer rs1 data from the selected producer; x0 always reads zero.
  always_comb begin
    w_rs1 = rs1_i;
    unique case (w_src1)
      FWD_EX:  w_rs1 = ex_result_i;
      FWD_MEM: w_rs1 = mem_result_i;
      FWD_WB:  w_rs1 = r_lwb_data;
      default: w_rs1 = (sel_rs1_i == '0) ? '0 : rs1_i;
    endcase
  end

  // Steer rs2 data from the selected producer; x0 always reads zero.
  always_comb begin
    w_rs2 = rs2_i;
    unique case (w_src2)
      FWD_EX:  w_rs2 = ex_result_i;
      FWD_MEM: w_rs2 = mem_result_i;
      FWD_WB:  w_rs2 = r_lwb_data;
      default: w_rs2 = (sel_rs2_i == '0) ? '0 : rs2_i;
    endcase
  end

  // Shadow of the regfile write that raced with this cycle's read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lwb_we   <= 1'b0;
      r_lwb_idx  <= '0;
      r_lwb_data <= '0;
    end else begin
      r_lwb_we   <= wb_we_i;
      r_lwb_idx  <= wb_sel_rd_i;
      r_lwb_data <= wb_rd_i;
    end
  end

  // Operand register: flush, hold on backpressure, bubble, or load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_valid   <= 1'b0;
      r_op_rs1     <= '0;
      r_op_rs2     <= '0;
      r_op_sel_rd  <= '0;
      r_op_rd_we   <= 1'b0;
      r_op_is_load <= 1'b0;
    end else if (flush_i) begin
      r_op_valid <= 1'b0;
    end else if (w_hold) begin
      r_op_valid <= r_op_valid;
    end else if (w_load_use) begin
      r_op_valid <= 1'b0;
    end else begin
      r_op_valid <= valid_i;
      if (valid_i) begin
        r_op_rs1     <= w_rs1;
        r_op_rs2     <= w_rs2;
        r_op_sel_rd  <= sel_rd_i;
        r_op_rd_we   <= rd_we_i;
        r_op_is_load <= is_load_i;
      end
    end
  end

  assign op_valid_o   = r_op_valid;
  assign op_rs1_o     = r_op_rs1;
  assign op_rs2_o     = r_op_rs2;
  assign op_sel_rd_o  = r_op_sel_rd;
  assign op_rd_we_o   = r_op_rd_we;
  assign op_is_load_o = r_op_is_load;

`ifdef RISKY_OPSTAGE_PERF_EN
  logic        w_accept;
  logic        w_fwd_any;
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_fwd;

  assign w_accept  = valid_i && !flush_i && !w_hold && !w_load_use;
  assign w_fwd_any = (w_src1 != FWD_RF) || (w_src2 != FWD_RF);

  // Free-running event counters, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= '0;
      r_perf_fwd   <= '0;
    end else begin
      if (w_stall)
        r_perf_stall <= r_perf_stall + 32'd1;
      if (w_accept && w_fwd_any)
        r_perf_fwd <= r_perf_fwd + 32'd1;
    end
  end

  assign perf_stall_cnt_o = r_perf_stall;
  assign perf_fwd_cnt_o   = r_perf_fwd;
`endif

endmodule

// File: tb/tb_operand_stage.sv
// Directed and random checks of operand_stage against a
// producer-list reference model.
module tb_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic [31:0] rs1_i, rs2_i;
  logic [4:0]  sel_rs1_i, sel_rs2_i, sel_rd_i;
  logic        rd_we_i, is_load_i;
  logic [31:0] ex_result_i;
  logic        mem_valid_i, mem_we_i;
  logic [4:0]  mem_sel_rd_i;
  logic [31:0] mem_result_i;
  logic        wb_we_i;
  logic [4:0]  wb_sel_rd_i;
  logic [31:0] wb_rd_i;
  logic        flush_i, ex_ready_i;
  logic        stall_o, op_valid_o;
  logic [31:0] op_rs1_o, op_rs2_o;
  logic [4:0]  op_sel_rd_o;
  logic        op_rd_we_o, op_is_load_o;
`ifdef RISKY_OPSTAGE_PERF_EN
  logic [31:0] perf_stall_cnt_o, perf_fwd_cnt_o;
`endif

  operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .valid_i(valid_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i),
    .sel_rs1_i(sel_rs1_i), .sel_rs2_i(sel_rs2_i),
    .sel_rd_i(sel_rd_i),
    .rd_we_i(rd_we_i), .is_load_i(is_load_i),
    .ex_result_i(ex_result_i),
    .mem_valid_i(mem_valid_i), .mem_we_i(mem_we_i),
    .mem_sel_rd_i(mem_sel_rd_i),
    .mem_result_i(mem_result_i),
    .wb_we_i(wb_we_i), .wb_sel_rd_i(wb_sel_rd_i),
    .wb_rd_i(wb_rd_i),
    .flush_i(flush_i), .ex_ready_i(ex_ready_i),
    .stall_o(stall_o), .op_valid_o(op_valid_o),
    .op_rs1_o(op_rs1_o), .op_rs2_o(op_rs2_o),
    .op_sel_rd_o(op_sel_rd_o),
    .op_rd_we_o(op_rd_we_o), .op_is_load_o(op_is_load_o)
`ifdef RISKY_OPSTAGE_PERF_EN
    ,
    .perf_stall_cnt_o(perf_stall_cnt_o),
    .perf_fwd_cnt_o(perf_fwd_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: what EX currently holds, and the last regfile write.
  bit          m_valid, m_we, m_load;
  logic [4:0]  m_rd;
  logic [31:0] m_rs1, m_rs2;
  bit          l_we;
  logic [4:0]  l_idx;
  logic [31:0] l_data;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] resolve(logic [4:0] sel,
                                          logic [31:0] rf);
    bit          en  [3];
    logic [4:0]  idx [3];
    logic [31:0] dat [3];
    if (sel == 5'd0) return 32'd0;
    en  = '{m_valid && m_we, mem_valid_i && mem_we_i, l_we};
    idx = '{m_rd, mem_sel_rd_i, l_idx};
    dat = '{ex_result_i, mem_result_i, l_data};
    for (int k = 0; k < 3; k++)
      if (en[k] && idx[k] == sel) return dat[k];
    return rf;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_we = 0; m_load = 0;
    m_rd = 0; m_rs1 = 0; m_rs2 = 0;
    l_we = 0; l_idx = 0; l_data = 0;
  endtask

  task automatic chk_outs(string tag);
    chk({tag, ".valid"}, op_valid_o, m_valid);
    chk({tag, ".rs1"},   op_rs1_o,   m_rs1);
    chk({tag, ".rs2"},   op_rs2_o,   m_rs2);
    chk({tag, ".rd"},    op_sel_rd_o, m_rd);
    chk({tag, ".we"},    op_rd_we_o, m_we);
    chk({tag, ".ld"},    op_is_load_o, m_load);
  endtask

  // One clock: check stall before the edge, outputs after it.
  task automatic cycle(string tag);
    bit lu, hold;
    logic [31:0] n1, n2;
    #1;
    lu = valid_i && m_valid && m_load && m_we && m_rd != 0
      && (m_rd == sel_rs1_i || m_rd == sel_rs2_i);
    hold = m_valid && !ex_ready_i;
    chk({tag, ".stall"}, stall_o, (lu || hold) && !flush_i);
    n1 = resolve(sel_rs1_i, rs1_i);
    n2 = resolve(sel_rs2_i, rs2_i);
    @(posedge clk);
    if (flush_i) m_valid = 0;
    else if (hold) m_valid = m_valid;
    else if (lu) m_valid = 0;
    else begin
      m_valid = valid_i;
      if (valid_i) begin
        m_rs1 = n1; m_rs2 = n2; m_rd = sel_rd_i;
        m_we = rd_we_i; m_load = is_load_i;
      end
    end
    l_we = wb_we_i; l_idx = wb_sel_rd_i; l_data = wb_rd_i;
    #1;
    chk_outs(tag);
  endtask

  task automatic clr();
    valid_i = 0; rs1_i = 0; rs2_i = 0;
    sel_rs1_i = 0; sel_rs2_i = 0; sel_rd_i = 0;
    rd_we_i = 0; is_load_i = 0; ex_result_i = 0;
    mem_valid_i = 0; mem_we_i = 0; mem_sel_rd_i = 0;
    mem_result_i = 0; wb_we_i = 0; wb_sel_rd_i = 0;
    wb_rd_i = 0; flush_i = 0; ex_ready_i = 1;
  endtask

  task automatic instr(logic [4:0] s1, logic [4:0] s2, logic [4:0] rd,
                       logic ld);
    valid_i = 1; sel_rs1_i = s1; sel_rs2_i = s2;
    sel_rd_i = rd; rd_we_i = 1; is_load_i = ld;
    rs1_i = 32'h1000 + s1; rs2_i = 32'h2000 + s2;
  endtask

  initial begin
    clr();
    rst_n = 0;
    model_reset();
    #12;
    chk_outs("reset");
    chk("reset.stall", stall_o, 0);
    @(negedge clk);
    rst_n = 1;

    // ADD x5 then ADD x6,x5,x0: EX forward
    instr(1, 2, 5, 0);
    cycle("add1");
    instr(5, 0, 6, 0);
    ex_result_i = 32'h11;
    cycle("add2");
    chk("ex_fwd", op_rs1_o, 32'h11);
    chk("ex_fwd.x0", op_rs2_o, 32'h0);

    // LW x7 then ADD x8,x7,x7: one bubble, then MEM forward
    instr(3, 4, 7, 1);
    cycle("lw");
    instr(7, 7, 8, 0);
    cycle("lu");
    chk("lu.bubble", op_valid_o, 0);
    mem_valid_i = 1; mem_we_i = 1;
    mem_sel_rd_i = 7; mem_result_i = 32'hDEAD;
    cycle("lu2");
    chk("lu.rs1", op_rs1_o, 32'hDEAD);
    chk("lu.rs2", op_rs2_o, 32'hDEAD);

    // Late-WB: write x3 on the edge the regfile sampled stale data
    clr();
    wb_we_i = 1; wb_sel_rd_i = 3; wb_rd_i = 32'h55;
    cycle("wb_w");
    clr();
    instr(3, 0, 9, 0);
    rs1_i = 0;
    cycle("wb_r");
    chk("lwb", op_rs1_o, 32'h55);
    clr();
    wb_we_i = 1; wb_sel_rd_i = 3; wb_rd_i = 32'h55;
    cycle("wb_w2");
    clr();
    instr(3, 0, 9, 0);
    rs1_i = 0;
    mem_valid_i = 1; mem_we_i = 1;
    mem_sel_rd_i = 3; mem_result_i = 32'h66;
    cycle("mem_win");
    chk("mem_over_wb", op_rs1_o, 32'h66);

    // x0 never forwarded
    clr();
    instr(0, 0, 10, 0);
    rs1_i = 32'h123;
    mem_valid_i = 1; mem_we_i = 1;
    mem_sel_rd_i = 0; mem_result_i = 32'hFF;
    cycle("x0");
    chk("x0.rs1", op_rs1_o, 32'h0);

    // Backpressure for 3 cycles, then flush during the hold
    clr();
    instr(1, 2, 11, 0);
    cycle("bp0");
    instr(4, 5, 12, 0);
    ex_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      cycle("bp");
      chk("bp.stall", stall_o, 1);
      chk("bp.rd", op_sel_rd_o, 5'd11);
    end
    flush_i = 1;
    cycle("flush");
    chk("flush.valid", op_valid_o, 0);
    clr();
    #1;
    chk("flush.nostall", stall_o, 0);

    // Random traffic over a small index space to provoke hazards
    for (int i = 0; i < 400; i++) begin
      valid_i      = ($urandom_range(0, 3) != 0);
      sel_rs1_i    = 5'($urandom_range(0, 3));
      sel_rs2_i    = 5'($urandom_range(0, 3));
      sel_rd_i     = 5'($urandom_range(0, 3));
      rd_we_i      = 1'($urandom);
      is_load_i    = 1'($urandom);
      rs1_i        = $urandom;
      rs2_i        = $urandom;
      ex_result_i  = $urandom;
      mem_valid_i  = 1'($urandom);
      mem_we_i     = 1'($urandom);
      mem_sel_rd_i = 5'($urandom_range(0, 3));
      mem_result_i = $urandom;
      wb_we_i      = 1'($urandom);
      wb_sel_rd_i  = 5'($urandom_range(0, 3));
      wb_rd_i      = $urandom;
      flush_i      = ($urandom_range(0, 19) == 0);
      ex_ready_i   = ($urandom_range(0, 4) != 0);
      cycle("rnd");
    end

    // Reset mid-operation with a pending late-WB write
    clr();
    instr(1, 2, 13, 1);
    wb_we_i = 1; wb_sel_rd_i = 3; wb_rd_i = 32'h77;
    cycle("pre_rst");
    chk("pre_rst.valid", op_valid_o, 1);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    chk_outs("midrst");
    chk("midrst.stall", stall_o, 0);
    @(negedge clk);
    rst_n = 1;
    clr();
    instr(3, 0, 14, 0);
    rs1_i = 32'hAB;
    cycle("post_rst");
    chk("post_rst.rf", op_rs1_o, 32'hAB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
